// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock sequencer: controller states, instruction
// phases and the smallest divisor the divider will accept.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_DRAINING = 2'd3
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_FETCH     = 2'd0;
  localparam phase_t PH_DECODE    = 2'd1;
  localparam phase_t PH_EXECUTE   = 2'd2;
  localparam phase_t PH_WRITEBACK = 2'd3;

  localparam int unsigned MIN_DIV = 2;

  // One-hot enable for a given phase index.
  function automatic logic [3:0] phase_onehot(input phase_t ph);
    return 4'b0001 << ph;
  endfunction

endpackage

// File: rtl/cpu_clock_sequencer_if.sv
// Control strobes in and phase timing out of the CPU clock sequencer.
interface cpu_clock_sequencer_if #(
  parameter int unsigned DIV_W = 28
);
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             run;
  logic             step;
  logic             halt;
  logic             tick;
  logic [3:0]       ph_en;
  logic [1:0]       phase;
  logic             instr_done;
  logic             clkout;
  logic [1:0]       state;

  modport master (
    output div_load, div_value, run, step, halt,
    input  tick, ph_en, phase, instr_done, clkout, state
  );

  modport slave (
    input  div_load, div_value, run, step, halt,
    output tick, ph_en, phase, instr_done, clkout, state
  );
endinterface

// File: rtl/cpu_clock_sequencer_tick_divider.sv
// Programmable period counter: one-cycle tick per div_reg cycles plus a
// ~50% duty clkout, both registered so they line up with the live count.
module tick_divider
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_W       = 28,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             div_load_i,
  input  logic [DIV_W-1:0] div_value_i,
  output logic             tick_o,
  output logic             tick_next_c,
  output logic             clkout_o
);

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);

  logic             run_q;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             clkout_q, clkout_d;
  logic             wrap_c;

  // run_q tracks whether the counter was live this cycle; enable_i is the
  // controller's next state, so outputs are computed for the upcoming count.
  always_comb begin
    div_d    = div_q;
    count_d  = '0;
    tick_d   = 1'b0;
    clkout_d = 1'b0;
    wrap_c   = (count_q == (div_q - ONE_V));

    if (div_load_i) begin
      div_d = (div_value_i < MIN_DIV_V) ? MIN_DIV_V : div_value_i;
    end

    if (!div_load_i && enable_i && run_q && !wrap_c) begin
      count_d = count_q + ONE_V;
    end

    tick_d   = enable_i && (count_d == (div_d - ONE_V));
    clkout_d = enable_i && (count_d < (div_d >> 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q    <= 1'b0;
      count_q  <= '0;
      div_q    <= DEF_DIV_V;
      tick_q   <= 1'b0;
      clkout_q <= 1'b0;
    end else begin
      run_q    <= enable_i;
      count_q  <= count_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      clkout_q <= clkout_d;
    end
  end

  assign tick_o      = tick_q;
  assign tick_next_c = tick_d && !rst_i;
  assign clkout_o    = clkout_q;

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Run/step/halt controller that gates divided ticks into four one-hot
// instruction-phase enables for a datapath clocked on clkin.
module cpu_clock_sequencer
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_W       = 28,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic                  clkin,
  input  logic                  reset,
  cpu_clock_sequencer_if.slave  bus
);

  state_e     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [3:0] ph_en_q, ph_en_d;
  logic       instr_done_q, instr_done_d;
  logic       tick;
  logic       tick_next_c;
  logic       clkout;
  logic       wb_c;
  logic       enable_c;

  tick_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_div (
    .clk_i       (clkin),
    .rst_i       (reset),
    .enable_i    (enable_c),
    .div_load_i  (bus.div_load),
    .div_value_i (bus.div_value),
    .tick_o      (tick),
    .tick_next_c (tick_next_c),
    .clkout_o    (clkout)
  );

  // A halt landing on the WRITEBACK tick is already at the boundary, so it
  // skips DRAINING and halts immediately.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ph_en_d      = 4'b0000;
    instr_done_d = 1'b0;
    wb_c         = tick && (phase_q == PH_WRITEBACK);

    case (state_q)
      ST_HALTED: begin
        if (bus.step) begin
          state_d = ST_STEPPING;
        end else if (bus.run) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (bus.halt) begin
          state_d = wb_c ? ST_HALTED : ST_DRAINING;
        end
      end
      ST_STEPPING: begin
        if (bus.halt) begin
          state_d = wb_c ? ST_HALTED : ST_DRAINING;
        end else if (bus.run) begin
          state_d = ST_RUNNING;
        end else if (wb_c) begin
          state_d = ST_HALTED;
        end
      end
      ST_DRAINING: begin
        if (wb_c) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    if (state_d == ST_HALTED) begin
      phase_d = PH_FETCH;
    end else if (tick) begin
      phase_d = phase_q + 2'd1;
    end

    if (tick_next_c) begin
      ph_en_d      = phase_onehot(phase_d);
      instr_done_d = (phase_d == PH_WRITEBACK);
    end
  end

  assign enable_c = (state_d != ST_HALTED);

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= ST_HALTED;
      phase_q      <= PH_FETCH;
      ph_en_q      <= 4'b0000;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ph_en_q      <= ph_en_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign bus.tick       = tick;
  assign bus.ph_en      = ph_en_q;
  assign bus.phase      = phase_q;
  assign bus.instr_done = instr_done_q;
  assign bus.clkout     = clkout;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Self-checking bench: directed scenarios plus random strobes, every cycle
// compared against a behavioural model of the sequencer.
module tb_cpu_clock_sequencer;

  localparam int unsigned DIV_W = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_clock_sequencer_if #(.DIV_W(DIV_W)) bus();

  cpu_clock_sequencer #(.DIV_W(DIV_W), .DEFAULT_DIV(16)) dut (
    .clkin (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model: state 0..3, count within period, divisor, phase index.
  int ms, mcnt, mdiv, mph;
  bit mvalid = 1'b0;
  int ticks_seen, clk_hi_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_active();
    return ms != 0;
  endfunction

  function automatic bit m_tick();
    return m_active() && (mcnt == mdiv - 1);
  endfunction

  task automatic model_edge(input bit r_rst, input bit dl, input int dv,
                            input bit r, input bit s, input bit h);
    int  ns, ncnt, nph;
    bit  tk, wb;
    if (r_rst) begin
      ms = 0; mdiv = 16; mcnt = 0; mph = 0; mvalid = 1'b1;
      return;
    end
    tk = m_tick();
    wb = tk && (mph == 3);
    ns = ms;
    case (ms)
      0: if (s) ns = 2; else if (r) ns = 1;
      1: if (h) ns = wb ? 0 : 3;
      2: if (h) ns = wb ? 0 : 3; else if (r) ns = 1; else if (wb) ns = 0;
      default: if (wb) ns = 0;
    endcase
    if (dl) ncnt = 0;
    else if (m_active()) ncnt = (mcnt + 1) % mdiv;
    else ncnt = 0;
    if (dl) mdiv = (dv < 2) ? 2 : dv;
    nph = tk ? (mph + 1) % 4 : mph;
    if (ns == 0) begin
      ncnt = 0; nph = 0;
    end
    ms = ns; mcnt = ncnt; mph = nph;
  endtask

  task automatic cyc(input bit r_rst, input bit dl, input int dv,
                     input bit r, input bit s, input bit h);
    bit tk;
    rst           = r_rst;
    bus.div_load  = dl;
    bus.div_value = DIV_W'(dv);
    bus.run       = r;
    bus.step      = s;
    bus.halt      = h;
    @(negedge clk);
    if (mvalid) begin
      tk = m_tick();
      check("tick",       32'(bus.tick),       32'(tk));
      check("ph_en",      32'(bus.ph_en),      tk ? (32'd1 << mph) : 32'd0);
      check("instr_done", 32'(bus.instr_done), 32'(tk && mph == 3));
      check("phase",      32'(bus.phase),      32'(mph));
      check("state",      32'(bus.state),      32'(ms));
      check("clkout",     32'(bus.clkout),     32'(m_active() && (mcnt < mdiv / 2)));
    end
    if (bus.tick) ticks_seen++;
    if (bus.clkout) clk_hi_seen++;
    @(posedge clk);
    model_edge(r_rst, dl, dv, r, s, h);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit found;
    bus.div_load = 0; bus.div_value = '0; bus.run = 0; bus.step = 0; bus.halt = 0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(3);

    // Free run at default divisor: ticks at 16,32,48,64,80 after the strobe.
    ticks_seen = 0;
    cyc(0, 0, 0, 1, 0, 0);
    idle(80);
    check("run16_ticks", 32'(ticks_seen), 32'd5);
    cyc(0, 0, 0, 0, 0, 1);
    idle(70);
    check("drain_halted", 32'(bus.state), 32'd0);

    // Single step at divisor 4.
    cyc(0, 1, 4, 0, 0, 0);
    ticks_seen = 0;
    cyc(0, 0, 0, 0, 1, 0);
    idle(24);
    check("step_ticks", 32'(ticks_seen), 32'd4);
    check("step_state", 32'(bus.state), 32'd0);
    check("step_phase", 32'(bus.phase), 32'd0);
    check("step_clkout", 32'(bus.clkout), 32'd0);

    // Halt in the cycle after the DECODE tick.
    cyc(0, 0, 0, 1, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_tick() && mph == 1) found = 1'b1;
      else cyc(0, 0, 0, 0, 0, 0);
    end
    check("decode_found", 32'(found), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    ticks_seen = 0;
    cyc(0, 0, 0, 0, 0, 1);
    idle(100);
    check("halt_after_decode_ticks", 32'(ticks_seen), 32'd2);

    // Clamp of tiny divisors, then a mid-run reload to 7.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    ticks_seen = 0;
    cyc(0, 0, 0, 1, 0, 0);
    idle(10);
    check("div2_ticks", 32'(ticks_seen), 32'd5);
    cyc(0, 1, 7, 0, 0, 0);
    ticks_seen = 0; clk_hi_seen = 0;
    idle(7);
    check("div7_ticks", 32'(ticks_seen), 32'd1);
    check("div7_clkout_high", 32'(clk_hi_seen), 32'd3);

    // Simultaneous strobes.
    cyc(0, 0, 0, 1, 0, 1);
    idle(1);
    check("run_halt_drain", 32'(bus.state), 32'd3);
    idle(40);
    cyc(0, 0, 0, 1, 1, 0);
    idle(1);
    check("step_run_stepping", 32'(bus.state), 32'd2);
    idle(40);

    // Reset in the middle of EXECUTE.
    cyc(0, 1, 5, 1, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mph == 2 && !m_tick()) found = 1'b1;
      else cyc(0, 0, 0, 0, 0, 0);
    end
    check("execute_found", 32'(found), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_ph_en", 32'(bus.ph_en), 32'd0);
    ticks_seen = 0;
    cyc(0, 0, 0, 1, 0, 0);
    idle(16);
    check("rst_div16_ticks", 32'(ticks_seen), 32'd1);

    // Random strobes, reloads and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 999) < 3,
          $urandom_range(0, 99) < 2, int'($urandom_range(0, 9)),
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_clock_sequencer.md
Name: cpu_clock_sequencer

Overview:
Generates the processor's instruction-phase timing from the board clock. A programmable divider produces a one-cycle tick every DIV clkin cycles. Each tick enables one of four instruction phases: FETCH, DECODE, EXECUTE, WRITEBACK. A run/step/halt controller gates the ticks. The block sits between the board clock and the microprocessor datapath. The datapath stays on clkin and uses ph_en as clock enables.

Parameters:
DIV_W, 28, width of the divisor and the cycle counter
DEFAULT_DIV, 16, divisor loaded at reset
MIN_DIV, 2, smallest divisor accepted; smaller values are clamped up to it

Ports:
clkin  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
div_load  in  1  one-cycle strobe; latch div_value
div_value  in  DIV_W  new divisor
run  in  1  one-cycle strobe; start free-running
step  in  1  one-cycle strobe; execute one instruction (4 phases), then stop
halt  in  1  one-cycle strobe; stop at the next instruction boundary
tick  out  1  one-cycle pulse per divided period while active
ph_en  out  4  one-hot phase enable, asserted only in the tick cycle; bit0=FETCH … bit3=WRITEBACK
phase  out  2  current phase index
instr_done  out  1  pulse coincident with the WRITEBACK tick
clkout  out  1  ~50% divided clock for LEDs/display; held low when HALTED
state  out  2  0=HALTED, 1=RUNNING, 2=STEPPING, 3=DRAINING

Behaviour:
- Reset: state=HALTED, div_reg=DEFAULT_DIV, count=0, phase=0.
- Reset: tick=0, ph_en=0, instr_done=0, clkout=0.
- Reset takes priority over every other input, including mid-instruction. Phase returns to FETCH.
- Divisor: on div_load, div_reg <= max(div_value, MIN_DIV) and count <= 0. The new period starts on the following cycle. The state is unchanged.
- Counter: counts 0..div_reg-1 and wraps, but only in non-HALTED states. In HALTED it is held at 0.
- tick: registered; asserted for exactly one cycle when count==div_reg-1 in a non-HALTED state.
- ph_en: equals (1<<phase) in the tick cycle, 0 otherwise.
- phase: advances mod 4 on the cycle after each tick.
- clkout: registered (count < div_reg/2) in non-HALTED states, else 0. With an odd div the high time is the floor half.
- Latency: a run strobe in cycle 0 gives state=RUNNING in cycle 1. The first tick is in cycle div_reg.
- Transitions. Strobe priority when several arrive in one cycle: halt > step > run.
- HALTED: run -> RUNNING; step -> STEPPING; halt is ignored.
- RUNNING: halt -> DRAINING; run and step are ignored.
- STEPPING: on the WRITEBACK tick -> HALTED.
  - run -> RUNNING; the current instruction continues.
  - halt -> DRAINING.
- DRAINING: on the WRITEBACK tick -> HALTED. run and step are ignored.
- Boundary: a halt arriving in the same cycle as a WRITEBACK tick still produces that tick and instr_done. State goes directly to HALTED with phase=FETCH.
- Boundary: a div_load while a strobe is pending restarts count but does not cancel the transition.
- Instruction boundary: entering HALTED always leaves phase=0 and count=0. The next run or step therefore starts at FETCH.
- Widths: count and div_reg are DIV_W bits unsigned. The comparison count==div_reg-1 is valid because div_reg>=2.

Decomposition:
- Shared package cpu_clk_pkg:
  - state encoding constants ST_HALTED/ST_RUNNING/ST_STEPPING/ST_DRAINING
  - phase constants PH_FETCH..PH_WRITEBACK
  - MIN_DIV
- One natural sub-module: tick_divider, holding the counter, div_reg, clamp and load logic, tick and clkout. Its inputs are enable, div_load and div_value.
- cpu_clock_sequencer holds the FSM, the phase counter and ph_en/instr_done.

Test Plan:
- Reset, then run with DIV=16 -> first tick at cycle 16 after the run strobe, then every 16 cycles. ph_en sequence 0001,0010,0100,1000,0001. instr_done pulses with 1000.
- step from HALTED, DIV=4 -> exactly 4 ticks at 4-cycle spacing, one instr_done, then state=HALTED, phase=0, clkout=0.
- run, then halt right after the DECODE tick -> EXECUTE and WRITEBACK ticks still occur, then HALTED. No further ticks over 100 cycles.
- div_load with div_value=0 and then 1 -> div_reg=2 and a tick every 2 cycles. div_value=7 mid-run -> count restarts, next tick 7 cycles later, clkout high 3 of 7 cycles.
- Simultaneous run+halt in RUNNING -> DRAINING. Simultaneous step+run in HALTED -> STEPPING.
- reset asserted mid-EXECUTE -> next cycle all outputs 0, state=HALTED, div_reg=16.
